addsub_arbiter: RTL
===================

# addsub_arbiter

Round-robin arbiter and sequencer that shares one signed add/subtract unit with overflow detection among `N_REQ` requesters. Each requester presents two operands and an op code through a valid/ready handshake. The block grants one requester at a time, computes the result in a registered stage, and returns the sum, the overflow flag and the requester id on a single response channel. It sits between the CPU's multi-cycle units (address generation, branch compare, debug port) and the shared adder/subtractor datapath.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 32, operand/result width, two's complement

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  N_REQ  per-requester request valid
- `req_ready`  out  N_REQ  per-requester accept strobe, one-hot or zero
- `req_op`  in  N_REQ  per-requester op: 0 = add (a+b), 1 = sub (a-b)
- `req_a`  in  N_REQ*WIDTH  operand a, requester i at bits [i*WIDTH +: WIDTH]
- `req_b`  in  N_REQ*WIDTH  operand b, same packing
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response consumer ready
- `rsp_id`  out  clog2(N_REQ)  index of the requester that owns the response
- `rsp_sum`  out  WIDTH  result, wraps modulo 2^WIDTH
- `rsp_ovf`  out  1  signed overflow of the result

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any `req_valid`, the round-robin grant picks index g, searching from `last+1` upward mod N_REQ. `req_ready[g]`=1 combinationally in the same cycle; on that edge latch `req_a[g]`, `req_b[g]`, `req_op[g]` and g, set `last`=g, go to EXEC. With no valid requests, stay in IDLE with `req_ready`=0.
- EXEC: compute and register the sum, the overflow flag and the id; go to RESP. `req_ready`=0.
- RESP: `rsp_valid`=1, outputs held stable. On an edge where `rsp_ready`=1, go to IDLE. `req_ready`=0 throughout.
- Add overflow: a[MSB]==b[MSB] and sum[MSB]!=a[MSB].
- Sub overflow: a[MSB]!=b[MSB] and diff[MSB]!=a[MSB]. Sub is implemented as a + ~b + 1 on the same adder.
- A requester must hold its valid and operands until it sees ready. Deasserting valid before ready is legal; that requester is then simply not granted.
- `req_ready` is never asserted outside IDLE, so at most one request is in flight.

## Timing
- Reset (rst=1 at an edge): state=IDLE, `last`=N_REQ-1 (requester 0 has first priority), `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_ovf`=0, `req_ready`=0. Reset mid-transaction discards it; no response is produced.
- Latency: request accepted at edge E0, result registered at E1, `rsp_valid` high in the cycle following E1. Best case, `rsp_valid` is seen 2 cycles after the accept cycle.
- Throughput: with `rsp_ready` tied high, one operation per 3 cycles. The next accept happens in the IDLE cycle after the response handshake edge.
- Backpressure: with `rsp_ready`=0, stay in RESP indefinitely; `rsp_*` are unchanged every cycle.
- Simultaneous requests: exactly one grant per IDLE cycle, rotating. A requester that keeps valid high is served within N_REQ transactions.
- Pointer wrap: `last`=N_REQ-1 searches from 0.

## Structure
- Shared header `addsub_defs.vh`:
  - op encodings `OP_ADD`=1'b0, `OP_SUB`=1'b1
  - FSM state encodings `S_IDLE`, `S_EXEC`, `S_RESP` (2 bits)
- Sub-module `rr_arbiter`:
  - combinational; inputs `req[N_REQ]`, `last`; outputs one-hot `grant` and `grant_idx`
  - reusable elsewhere in the CPU
- The add/sub/overflow logic stays inline in `addsub_arbiter`.

## Test plan
- WIDTH=3, N_REQ=4. Requester 0 only, add 3+1 -> `rsp_sum`=3'b100, `rsp_ovf`=1, `rsp_id`=0, `rsp_valid` 2 cycles after the accept.
- Requester 2 only, sub (-4)-1 -> `rsp_sum`=3'b011, `rsp_ovf`=1. Then sub 2-3 -> 3'b111, `rsp_ovf`=0.
- All four requesters valid continuously from reset -> grant order 0,1,2,3,0. `req_ready` one-hot, one accept every 3 cycles with `rsp_ready`=1.
- `rsp_ready` held low 5 cycles in RESP -> `rsp_*` stable, no `req_ready` asserted. Release -> IDLE and the next grant on the following cycle.
- rst pulsed during EXEC -> no `rsp_valid`, all outputs 0. The next grant goes to requester 0.
- Exhaustive sweep of all 3-bit a, b for both ops, matched against a reference model for sum and overflow.

Source files
------------

// File: rtl/addsub_arbiter_pkg.sv
// Shared definitions for the add/sub arbiter: op codes and sequencer states.
package addsub_arbiter_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/addsub_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last+1 upward (mod N_REQ)
// and returns a one-hot grant plus its index.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx
);

  localparam int IDW = $clog2(N_REQ);

  logic [IDW-1:0] cand;
  logic           found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IDW'((32'(last) + k) % N_REQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    grant = N_REQ'(found) << grant_idx;
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin sequencer sharing one registered signed add/sub unit with
// overflow detection among N_REQ requesters; one operation in flight at a time.
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ-1:0]         req_op,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_ovf
);

  localparam int IDW = $clog2(N_REQ);

  state_e         state_q, state_d;
  logic [IDW-1:0] last_q, last_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  op_e            op_q, op_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic           ovf_q, ovf_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;

  logic [N_REQ-1:0] grant;
  logic [IDW-1:0]   grant_idx;
  logic [WIDTH-1:0] b_eff, sum_w;
  logic             ovf_w;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req      (req_valid),
    .last     (last_q),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  // Sub is a + ~b + 1; testing overflow against the inverted b folds the
  // add and sub overflow rules into one expression.
  always_comb begin
    b_eff = (op_q == OP_SUB) ? ~b_q : b_q;
    sum_w = a_q + b_eff + WIDTH'(op_q == OP_SUB);
    ovf_w = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    rsp_id_d  = rsp_id_q;
    req_ready = '0;
    unique case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          req_ready = grant;
          a_d       = req_a[grant_idx*WIDTH +: WIDTH];
          b_d       = req_b[grant_idx*WIDTH +: WIDTH];
          op_d      = op_e'(req_op[grant_idx]);
          last_d    = grant_idx;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        sum_d    = sum_w;
        ovf_d    = ovf_w;
        rsp_id_d = last_q;
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      last_q   <= IDW'(N_REQ - 1);
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
      rsp_id_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      sum_q    <= sum_d;
      ovf_q    <= ovf_d;
      rsp_id_q <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = sum_q;
  assign rsp_ovf   = ovf_q;

endmodule
